// File: rtl/md_sequencer.sv
// md_sequencer
//   Multicycle control sequencer living beside the single-cycle decoder.
//   Issues mul/div start pulses to the iterative multdiv unit, stalls the
//   pipeline while it runs, then writes the result back to the captured
//   destination register or raises a $rstatus exception. It also encodes the
//   single-cycle ALU overflow exceptions (add/addi/sub), so every write to
//   $rstatus comes from this one block.
//
//   Optional feature: define MD_TIMEOUT_EN to enable a busy-cycle watchdog
//   that aborts a mul/div after MD_TIMEOUT busy cycles with CODE_TMO.
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-high reset
//   in_valid, opcode, func   instruction in decode (func used when opcode=0)
//   rd_in, overflow          destination reg and ALU overflow of that instr
//   md_ready, md_exception   multdiv completion (exception qualified by ready)
//   ctrl_mult, ctrl_div      one-cycle start pulses
//   stall                    freeze PC, F/D and D/X latches
//   busy                     FSM is in BUSY (state visibility)
//   md_we, md_rd             result writeback enable and destination
//   setr, data_rstatus       write zero-extended exception code to r30
//
// Handshake: the multdiv unit is started by a single-cycle ctrl_mult/ctrl_div
// pulse and answers with md_ready held high for exactly one cycle; there is
// no back-pressure in either direction. md_ready is only honoured in BUSY.
module md_sequencer #(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 6,
  parameter int MD_TIMEOUT = 40,
  parameter int CODE_ADD   = 1,
  parameter int CODE_ADDI  = 2,
  parameter int CODE_SUB   = 3,
  parameter int CODE_MUL   = 4,
  parameter int CODE_DIV   = 5,
  parameter int CODE_TMO   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [4:0]        opcode,
  input  logic [4:0]        func,
  input  logic [4:0]        rd_in,
  input  logic              overflow,
  input  logic              md_ready,
  input  logic              md_exception,
  output logic              ctrl_mult,
  output logic              ctrl_div,
  output logic              stall,
  output logic              busy,
  output logic              md_we,
  output logic [4:0]        md_rd,
  output logic              setr,
  output logic [DATA_W-1:0] data_rstatus
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  localparam logic [DATA_W-1:0] C_ADD  = DATA_W'(CODE_ADD);
  localparam logic [DATA_W-1:0] C_ADDI = DATA_W'(CODE_ADDI);
  localparam logic [DATA_W-1:0] C_SUB  = DATA_W'(CODE_SUB);
  localparam logic [DATA_W-1:0] C_MUL  = DATA_W'(CODE_MUL);
  localparam logic [DATA_W-1:0] C_DIV  = DATA_W'(CODE_DIV);
  localparam logic [DATA_W-1:0] C_TMO  = DATA_W'(CODE_TMO);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic             kind_q, kind_d;   // 1 = divide in flight, 0 = multiply

  // Instruction decode
  logic is_r, is_mul, is_div, is_add, is_sub, is_addi;
  assign is_r    = (opcode == 5'b00000);
  assign is_mul  = is_r && (func == 5'b00110);
  assign is_div  = is_r && (func == 5'b00111);
  assign is_add  = is_r && (func == 5'b00000);
  assign is_sub  = is_r && (func == 5'b00001);
  assign is_addi = (opcode == 5'b00101);

  logic tmo_hit;
  assign tmo_hit = (cnt_q == TMO_LAST);
`ifndef MD_TIMEOUT_EN
  // Watchdog compiled out: keep its terms referenced so they stay lint-quiet.
  logic unused_tmo;
  assign unused_tmo = tmo_hit ^ (|C_TMO);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      kind_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      kind_q  <= kind_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_d         = rd_q;
    kind_d       = kind_q;
    ctrl_mult    = 1'b0;
    ctrl_div     = 1'b0;
    stall        = 1'b0;
    md_we        = 1'b0;
    setr         = 1'b0;
    data_rstatus = '0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && (is_mul || is_div)) begin
          ctrl_mult = is_mul;
          ctrl_div  = is_div;
          stall     = 1'b1;
          rd_d      = rd_in;
          kind_d    = is_div;
          cnt_d     = '0;
          state_d   = S_BUSY;
        end else if (in_valid && overflow && (is_add || is_addi || is_sub)) begin
          setr = 1'b1;
          if (is_addi)     data_rstatus = C_ADDI;
          else if (is_add) data_rstatus = C_ADD;
          else             data_rstatus = C_SUB;
        end
      end
      S_BUSY: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (md_ready) begin
          // Completion cycle: release the stall so the mul/div leaves decode.
          state_d = S_IDLE;
          if (md_exception) begin
            setr         = 1'b1;
            data_rstatus = kind_q ? C_DIV : C_MUL;
          end else begin
            md_we = (rd_q != 5'd0);   // writes to r0 are dropped
          end
        end else begin
          stall = 1'b1;
`ifdef MD_TIMEOUT_EN
          if (tmo_hit) begin
            stall        = 1'b0;
            setr         = 1'b1;
            data_rstatus = C_TMO;
            state_d      = S_IDLE;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are forced quiet while reset is held, even mid-operation.
    if (reset) begin
      ctrl_mult    = 1'b0;
      ctrl_div     = 1'b0;
      stall        = 1'b0;
      md_we        = 1'b0;
      setr         = 1'b0;
      data_rstatus = '0;
    end
  end

  assign busy  = !reset && (state_q == S_BUSY);
  assign md_rd = reset ? 5'd0 : rd_q;

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  opcode, func, rd_in;
  logic        overflow, md_ready, md_exception;
  logic        ctrl_mult, ctrl_div, stall, busy, md_we, setr;
  logic [4:0]  md_rd;
  logic [31:0] data_rstatus;

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_rd;

  md_sequencer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .opcode(opcode),
    .func(func), .rd_in(rd_in), .overflow(overflow), .md_ready(md_ready),
    .md_exception(md_exception), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .stall(stall), .busy(busy), .md_we(md_we), .md_rd(md_rd), .setr(setr),
    .data_rstatus(data_rstatus)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    in_valid = 0; opcode = 0; func = 0; rd_in = 0;
    overflow = 0; md_ready = 0; md_exception = 0;
  endtask

  task automatic drive_instr(input logic [4:0] op, input logic [4:0] fn,
                             input logic [4:0] rd, input logic ovf);
    in_valid = 1; opcode = op; func = fn; rd_in = rd; overflow = ovf;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset, with a mul presented: everything must stay quiet.
    drive_idle();
    reset = 1;
    drive_instr(5'd0, 5'd6, 5'd3, 1'b0);
    sample();
    check("rst_stall", stall, 0);
    check("rst_mult", ctrl_mult, 0);
    check("rst_busy", busy, 0);
    check("rst_md_rd", md_rd, 0);
    next_cycle();
    next_cycle();
    reset = 0;
    drive_idle();
    sample();
    check("idle_stall", stall, 0);
    next_cycle();

    // mul rd=7, ready at T5; ALU overflow at T2 must be masked.
    drive_instr(5'd0, 5'd6, 5'd7, 1'b0);
    exp_q.push_back(5'd7);
    sample();
    check("t1_mult_t0", ctrl_mult, 1);
    check("t1_div_t0", ctrl_div, 0);
    check("t1_stall_t0", stall, 1);
    check("t1_busy_t0", busy, 0);
    next_cycle();
    for (int t = 1; t <= 4; t++) begin
      drive_idle();
      if (t == 2) drive_instr(5'd0, 5'd0, 5'd2, 1'b1);
      sample();
      check("t1_stall_busy", stall, 1);
      check("t1_busy", busy, 1);
      check("t1_mult_busy", ctrl_mult, 0);
      check("t1_setr_masked", setr, 0);
      check("t1_we_busy", md_we, 0);
      next_cycle();
    end
    drive_idle();
    md_ready = 1;
    sample();
    exp_rd = exp_q.pop_front();
    check("t1_we_t5", md_we, 1);
    check("t1_rd_t5", md_rd, exp_rd);
    check("t1_stall_t5", stall, 0);
    check("t1_setr_t5", setr, 0);
    next_cycle();
    drive_idle();
    sample();
    check("t1_busy_t6", busy, 0);
    check("t1_stall_t6", stall, 0);
    next_cycle();

    // div with exception at T3 -> code 5
    drive_instr(5'd0, 5'd7, 5'd9, 1'b0);
    sample();
    check("t2_div_t0", ctrl_div, 1);
    check("t2_mult_t0", ctrl_mult, 0);
    next_cycle();
    drive_idle(); sample(); check("t2_stall_t1", stall, 1); next_cycle();
    drive_idle(); sample(); check("t2_stall_t2", stall, 1); next_cycle();
    md_ready = 1; md_exception = 1;
    sample();
    check("t2_setr_t3", setr, 1);
    check("t2_code_t3", data_rstatus, 5);
    check("t2_we_t3", md_we, 0);
    check("t2_stall_t3", stall, 0);
    next_cycle();
    drive_idle(); sample(); check("t2_busy_t4", busy, 0); next_cycle();

    // mul with exception at T1 (minimum occupancy) -> code 4
    drive_instr(5'd0, 5'd6, 5'd4, 1'b0);
    sample(); check("t2b_stall_t0", stall, 1); next_cycle();
    drive_idle(); md_ready = 1; md_exception = 1;
    sample();
    check("t2b_code_t1", data_rstatus, 4);
    check("t2b_setr_t1", setr, 1);
    next_cycle();

    // ALU overflow on consecutive IDLE cycles: add, addi, sub
    drive_instr(5'd0, 5'd0, 5'd1, 1'b1);
    sample(); check("t3_add_setr", setr, 1); check("t3_add_code", data_rstatus, 1);
    check("t3_add_stall", stall, 0); next_cycle();
    drive_instr(5'd5, 5'd0, 5'd1, 1'b1);
    sample(); check("t3_addi_setr", setr, 1); check("t3_addi_code", data_rstatus, 2);
    check("t3_addi_stall", stall, 0); next_cycle();
    drive_instr(5'd0, 5'd1, 5'd1, 1'b1);
    sample(); check("t3_sub_setr", setr, 1); check("t3_sub_code", data_rstatus, 3);
    check("t3_sub_stall", stall, 0); next_cycle();
    drive_instr(5'd0, 5'd0, 5'd1, 1'b0);
    sample(); check("t3_noovf_setr", setr, 0); check("t3_noovf_code", data_rstatus, 0);
    next_cycle();
    drive_instr(5'd0, 5'd1, 5'd1, 1'b1); in_valid = 0;
    sample(); check("t3_invalid_setr", setr, 0); next_cycle();
    drive_idle(); md_ready = 1; md_exception = 1;
    sample(); check("t3_ready_idle_setr", setr, 0); check("t3_ready_idle_we", md_we, 0);
    next_cycle();

    // mul rd=0, ready at T2: write suppressed
    drive_instr(5'd0, 5'd6, 5'd0, 1'b0);
    sample(); next_cycle();
    drive_idle(); sample(); check("t4_stall_t1", stall, 1); next_cycle();
    md_ready = 1;
    sample();
    check("t4_we_r0", md_we, 0);
    check("t4_setr_r0", setr, 0);
    check("t4_stall_t2", stall, 0);
    next_cycle();
    drive_idle(); sample(); check("t4_busy_t3", busy, 0); next_cycle();

    // reset at T2 of a div aborts it
    drive_instr(5'd0, 5'd7, 5'd12, 1'b0);
    sample(); next_cycle();
    drive_idle(); sample(); check("t5_busy_t1", busy, 1); next_cycle();
    reset = 1;
    sample(); check("t5_stall_rst", stall, 0); check("t5_busy_rst", busy, 0); next_cycle();
    reset = 0;
    sample(); check("t5_busy_t3", busy, 0); check("t5_rd_t3", md_rd, 0); next_cycle();
    md_ready = 1; md_exception = 0;
    sample(); check("t5_we_t4", md_we, 0); check("t5_setr_t4", setr, 0); next_cycle();
    md_ready = 1; md_exception = 1;
    sample(); check("t5_setr_t5", setr, 0); next_cycle();

    // watchdog: mul with md_ready never asserted
    drive_instr(5'd0, 5'd6, 5'd5, 1'b0);
    sample(); next_cycle();
    drive_idle();
    for (int t = 1; t <= 39; t++) begin
      sample();
      if (t == 1 || t == 39) begin
        check("t6_stall_wait", stall, 1);
        check("t6_setr_wait", setr, 0);
      end
      next_cycle();
    end
    sample();
`ifdef MD_TIMEOUT_EN
    check("t6_tmo_setr", setr, 1);
    check("t6_tmo_code", data_rstatus, 6);
    check("t6_tmo_stall", stall, 0);
    check("t6_tmo_we", md_we, 0);
    next_cycle();
    sample(); check("t6_busy_after", busy, 0); next_cycle();
`else
    check("t6_nt_setr_t40", setr, 0);
    check("t6_nt_stall_t40", stall, 1);
    next_cycle();
    for (int t = 41; t <= 100; t++) begin
      sample();
      if (t == 100) begin
        check("t6_nt_stall_t100", stall, 1);
        check("t6_nt_busy_t100", busy, 1);
      end
      next_cycle();
    end
    md_ready = 1;
    sample();
    check("t6_nt_we", md_we, 1);
    check("t6_nt_rd", md_rd, 5);
    next_cycle();
    drive_idle();
    sample(); check("t6_nt_busy_after", busy, 0); next_cycle();
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multicycle control sequencer that sits beside the single-cycle control decoder in the decode/execute stage. It issues multiply/divide operations to the iterative multdiv unit and stalls the pipeline while the operation runs. It then either writes the result back to the captured destination register or raises a status exception. It also absorbs the single-cycle ALU overflow exceptions (add/addi/sub) so that all writes to `$rstatus` come from one encoder with a parametrised code map.

## Interface

**Parameters**
- DATA_W, 32: width of `data_rstatus`.
- CNT_W, 6: width of the busy-cycle counter.
- MD_TIMEOUT, 40: busy cycles before watchdog abort; must be ≤ 2^CNT_W − 1.
- CODE_ADD, 1 / CODE_ADDI, 2 / CODE_SUB, 3 / CODE_MUL, 4 / CODE_DIV, 5 / CODE_TMO, 6: `$rstatus` exception codes.

**Ports**
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode holds a valid instruction.
- opcode  in  5  instruction opcode.
- func  in  5  ALU func field; only meaningful when opcode = 00000.
- rd_in  in  5  destination register of the instruction in decode.
- overflow  in  1  ALU overflow for the instruction in decode.
- md_ready  in  1  multdiv result valid; held for one cycle.
- md_exception  in  1  multdiv overflow/div-by-zero; qualified by md_ready.
- ctrl_mult  out  1  one-cycle multiply start pulse.
- ctrl_div  out  1  one-cycle divide start pulse.
- stall  out  1  freeze PC, F/D and D/X latches.
- busy  out  1  FSM in BUSY.
- md_we  out  1  write the multdiv result to md_rd this cycle.
- md_rd  out  5  captured destination register.
- setr  out  1  write data_rstatus to r30 this cycle.
- data_rstatus  out  DATA_W  zero-extended exception code.

## Operation

**Decode**
- mul: opcode 00000, func 00110.
- div: opcode 00000, func 00111.
- add: opcode 00000, func 00000.
- sub: opcode 00000, func 00001.
- addi: opcode 00101.

**States**: IDLE, BUSY.

**IDLE**
- On in_valid & (mul | div), all combinational in this cycle:
  - ctrl_mult or ctrl_div = 1.
  - stall = 1.
- At the next edge: capture rd_in into md_rd, the op type into a kind flag, clear the counter to 0, go to BUSY.
- On in_valid & (add | addi | sub) & overflow: setr = 1, data_rstatus = CODE_ADD / CODE_ADDI / CODE_SUB. No state change.
- md_ready is ignored in IDLE.

**BUSY**
- Counter increments every cycle and saturates at 2^CNT_W − 1.
- ALU overflow path is masked.
- ctrl_mult and ctrl_div stay 0.
- md_ready = 0: stall = 1, remain in BUSY.
- md_ready = 1 and md_exception = 0:
  - md_we = 1, unless md_rd = 0, which suppresses the write.
  - stall = 0, next state IDLE.
- md_ready = 1 and md_exception = 1:
  - setr = 1, data_rstatus = CODE_MUL or CODE_DIV according to the kind flag.
  - md_we = 0, stall = 0, next state IDLE.
- The completion cycle releases the stall. The mul/div instruction leaves decode in that cycle. The next instruction decodes in the following cycle and is never issued in the completion cycle.

**Reset**
- State = IDLE, counter = 0, md_rd = 0, kind flag = 0.
- Reset dominates any in-flight BUSY. No writeback or exception is produced for the aborted op.

**Output values**
- All outputs are combinational from state, registers and inputs.
- Every output is 0 while reset is high.
- data_rstatus = 0 whenever setr = 0.

## Timing

- Issue cycle T0: start pulse and stall high together.
- T1 onward: BUSY.
- md_ready at Tn (n ≥ 1): writeback or exception in Tn, stall low in Tn, IDLE at Tn+1.
- Total stall = n cycles (T0 … Tn−1).
- Minimum mul/div occupancy is 2 cycles: T0 plus a completion cycle at T1.
- ALU overflow exception: zero latency, same cycle as decode.

## Configuration

**`MD_TIMEOUT_EN`**
- Defined:
  - In BUSY with md_ready = 0 and counter = MD_TIMEOUT − 1: setr = 1, data_rstatus = CODE_TMO, md_we = 0, stall = 0, next state IDLE.
  - md_ready in the same cycle wins over the timeout.
- Undefined:
  - No watchdog; BUSY waits indefinitely.
  - CODE_TMO is never produced.

## Test plan

- mul with rd = 7, md_ready asserted at T5 → ctrl_mult pulses only at T0; stall high T0–T4; md_we = 1 with md_rd = 7 at T5; busy = 0 at T6.
- div with md_ready and md_exception at T3 → setr = 1 with data_rstatus = 5 at T3; md_we = 0; stall = 0 at T3.
- add with overflow, then addi with overflow, then sub with overflow on consecutive cycles in IDLE → setr with codes 1, 2, 3 on the same cycles; no stall.
- mul with rd = 0, md_ready at T2 → md_we = 0, setr = 0, return to IDLE.
- reset at T2 of a div → IDLE at T3; md_ready at T4 produces no md_we and no setr.
- `MD_TIMEOUT_EN` with MD_TIMEOUT = 40 and md_ready never asserted → setr with code 6 at T40; stall low at T40; a second build without the macro stays stalled at T100.
